// File: rtl/mem_sequencer.sv
// mem_sequencer: multi-cycle access sequencer and two-port arbiter for the
// SAP-2 byte-wide memory (MAR/MDR, return-address slot at FFFE/FFFF).
// Optional feature macro: MEMSEQ_LOADER_EN enables the program-loader write
// port and the round-robin arbiter; when undefined the CPU is always granted
// and ldr_ack is tied low.
module mem_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [2:0]  cpu_op,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        ldr_req,
  input  logic [15:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ldr_ack,
  input  logic [15:0] mem_out,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  output logic        mar_loadh,
  output logic        mar_loadl,
  output logic        mdr_load,
  output logic        ram_load,
  output logic        ram_enh,
  output logic        ram_enl,
  output logic        call,
  output logic        ret,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_MARA = 4'd1,
    S_RDH  = 4'd2,
    S_MARB = 4'd3,
    S_RDL  = 4'd4,
    S_MDR  = 4'd5,
    S_WR   = 4'd6,
    S_STK  = 4'd7,
    S_DONE = 4'd8
  } state_t;

  localparam logic [2:0] OP_READ_B  = 3'd0;
  localparam logic [2:0] OP_READ_W  = 3'd1;
  localparam logic [2:0] OP_WRITE_B = 3'd2;
  localparam logic [2:0] OP_CALL    = 3'd3;
  localparam logic [2:0] OP_RET     = 3'd4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  // FSM state and the request latched at grant time
  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        port_q, port_d;
  logic        grant_ldr;

  // Registered Moore outputs, computed from the next state
  logic [15:0] bus_out_q, bus_out_d;
  logic        bus_oe_q, bus_oe_d;
  logic        mar_load_q, mar_load_d;
  logic        mdr_load_q, mdr_load_d;
  logic        ram_load_q, ram_load_d;
  logic        ram_enh_q, ram_enh_d;
  logic        ram_enl_q, ram_enl_d;
  logic        call_q, call_d;
  logic        ret_q, ret_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        ldr_ack_q, ldr_ack_d;
  logic        busy_q, busy_d;

`ifdef MEMSEQ_LOADER_EN
  logic last_grant_q, last_grant_d;

  // Round-robin: a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    grant_ldr = ldr_req && (!cpu_req || (last_grant_q == PORT_CPU));
  end
`else
  // Loader compiled out: its inputs are ignored and the CPU always wins
  assign grant_ldr = 1'b0;
  logic unused_ldr;
  assign unused_ldr = ^{ldr_req, ldr_addr, ldr_wdata, ldr_ack_q};
`endif

  // Next-state logic: grant and latch in IDLE, then walk the op's step sequence
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    port_d  = port_q;
`ifdef MEMSEQ_LOADER_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req || grant_ldr) begin
`ifdef MEMSEQ_LOADER_EN
          last_grant_d = grant_ldr ? PORT_LDR : PORT_CPU;
          if (grant_ldr) begin
            port_d  = PORT_LDR;
            op_d    = OP_WRITE_B;
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
          end else begin
            port_d  = PORT_CPU;
            op_d    = cpu_op;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
`else
          port_d  = PORT_CPU;
          op_d    = cpu_op;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
`endif
          case (op_d)
            OP_READ_B, OP_READ_W, OP_WRITE_B: state_d = S_MARA;
            OP_CALL, OP_RET:                  state_d = S_STK;
            default:                          state_d = S_DONE;
          endcase
        end
      end
      S_MARA: begin
        case (op_q)
          OP_READ_W:  state_d = S_RDH;
          OP_WRITE_B: state_d = S_MDR;
          default:    state_d = S_RDL;
        endcase
      end
      S_RDH:   state_d = S_MARB;
      S_MARB:  state_d = S_RDL;
      S_RDL:   state_d = S_DONE;
      S_MDR:   state_d = S_WR;
      S_WR:    state_d = S_DONE;
      S_STK:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode for the state being entered, so every strobe leaves a flop
  always_comb begin
    bus_out_d  = 16'h0000;
    bus_oe_d   = 1'b0;
    mar_load_d = 1'b0;
    mdr_load_d = 1'b0;
    ram_load_d = 1'b0;
    ram_enh_d  = 1'b0;
    ram_enl_d  = 1'b0;
    call_d     = 1'b0;
    ret_d      = 1'b0;
    cpu_ack_d  = 1'b0;
    ldr_ack_d  = 1'b0;
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_MARA: begin
        bus_out_d  = addr_d;
        bus_oe_d   = 1'b1;
        mar_load_d = 1'b1;
      end
      S_RDH: ram_enh_d = 1'b1;
      S_MARB: begin
        // low byte of a word lives at addr+1; FFFF wraps to 0000
        bus_out_d  = addr_d + 16'd1;
        bus_oe_d   = 1'b1;
        mar_load_d = 1'b1;
      end
      S_RDL: ram_enl_d = 1'b1;
      S_MDR: begin
        bus_out_d  = {8'h00, wdata_d};
        bus_oe_d   = 1'b1;
        mdr_load_d = 1'b1;
      end
      S_WR: ram_load_d = 1'b1;
      S_STK: begin
        if (op_d == OP_CALL) begin
          bus_out_d = addr_d;
          bus_oe_d  = 1'b1;
          call_d    = 1'b1;
        end else begin
          ret_d = 1'b1;
        end
      end
      S_DONE: begin
        if (port_d == PORT_LDR) ldr_ack_d = 1'b1;
        else                    cpu_ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer FSM: state, latched request and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      port_q     <= PORT_CPU;
      bus_out_q  <= 16'h0000;
      bus_oe_q   <= 1'b0;
      mar_load_q <= 1'b0;
      mdr_load_q <= 1'b0;
      ram_load_q <= 1'b0;
      ram_enh_q  <= 1'b0;
      ram_enl_q  <= 1'b0;
      call_q     <= 1'b0;
      ret_q      <= 1'b0;
      cpu_ack_q  <= 1'b0;
      ldr_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MEMSEQ_LOADER_EN
      last_grant_q <= PORT_LDR;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      port_q     <= port_d;
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      mar_load_q <= mar_load_d;
      mdr_load_q <= mdr_load_d;
      ram_load_q <= ram_load_d;
      ram_enh_q  <= ram_enh_d;
      ram_enl_q  <= ram_enl_d;
      call_q     <= call_d;
      ret_q      <= ret_d;
      cpu_ack_q  <= cpu_ack_d;
      ldr_ack_q  <= ldr_ack_d;
      busy_q     <= busy_d;
`ifdef MEMSEQ_LOADER_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Read data rides with the CPU ack; MDR contents pass straight through in DONE
  always_comb begin
    cpu_rdata = 16'h0000;
    if (cpu_ack_q) begin
      case (op_q)
        OP_READ_B:         cpu_rdata = {8'h00, mem_out[7:0]};
        OP_READ_W, OP_RET: cpu_rdata = mem_out;
        default:           cpu_rdata = 16'h0000;
      endcase
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_oe    = bus_oe_q;
  assign mar_loadh = mar_load_q;
  assign mar_loadl = mar_load_q;
  assign mdr_load  = mdr_load_q;
  assign ram_load  = ram_load_q;
  assign ram_enh   = ram_enh_q;
  assign ram_enl   = ram_enl_q;
  assign call      = call_q;
  assign ret       = ret_q;
  assign cpu_ack   = cpu_ack_q;
  assign busy      = busy_q;
`ifdef MEMSEQ_LOADER_EN
  assign ldr_ack   = ldr_ack_q;
`else
  assign ldr_ack   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: random and directed checks of mem_sequencer against an
// op-level reference (latency table + golden byte memory), with a small
// behavioural SAP-2 memory block driven by the DUT strobes.
module tb_mem_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [2:0]  cpu_op;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        ldr_req;
  logic [15:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic        ldr_ack;
  logic [15:0] mem_out;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_sequencer dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .mem_out(mem_out), .bus_out(bus_out), .bus_oe(bus_oe),
    .mar_loadh(mar_loadh), .mar_loadl(mar_loadl), .mdr_load(mdr_load), .ram_load(ram_load),
    .ram_enh(ram_enh), .ram_enl(ram_enl), .call(call), .ret(ret), .busy(busy)
  );

  // Power-on contents of any byte never written
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return (a[15:8] * 8'd7) ^ a[7:0] ^ 8'h3C;
  endfunction

  // ---------------- memory block (environment) ----------------
  logic [7:0]  ram [logic [15:0]];
  logic [15:0] mar = 16'h0000;
  logic [15:0] mdr = 16'h0000;
  assign mem_out = mdr;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mar_loadh) mar[15:8] <= bus_out[15:8];
    if (mar_loadl) mar[7:0]  <= bus_out[7:0];
    if (mdr_load)  mdr[7:0]  <= bus_out[7:0];
    if (ram_enh)   mdr[15:8] <= mem_rd(mar);
    if (ram_enl)   mdr[7:0]  <= mem_rd(mar);
    if (ram_load)  ram[mar] = mdr[7:0];
    if (call) begin
      ram[16'hFFFE] = bus_out[15:8];
      ram[16'hFFFF] = bus_out[7:0];
    end
    if (ret) mdr <= {mem_rd(16'hFFFE), mem_rd(16'hFFFF)};
  end

  // ---------------- reference model ----------------
  logic [7:0] gold [logic [15:0]];
  function automatic logic [7:0] gold_rd(input logic [15:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  // observation state, only touched by the main process
  int          cnt [7];  // mar, rdh, rdl, mdr, wr, call, ret
  logic [15:0] q_bus [$];
  bit          prev_cpu_ack = 0, prev_ldr_ack = 0;
  bit          in_done = 0;  // last op left its request up, DUT sits in DONE

  // one clock; checks the cycle-wide invariants and records strobes/bus values
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (!rst) begin
      vectors++;
      if (!bus_oe && bus_out !== 16'h0000) begin
        miscompares++; $display("FAIL bus_idle_zero: got %h want 0000", bus_out);
      end
      if (bus_oe !== (mar_loadh | mdr_load | call)) begin
        miscompares++; $display("FAIL bus_oe_decode: got %b want %b", bus_oe, mar_loadh | mdr_load | call);
      end
      if (mar_loadh !== mar_loadl) begin
        miscompares++; $display("FAIL mar_pair: got h=%b l=%b want equal", mar_loadh, mar_loadl);
      end
      if ($countones({mar_loadh, ram_enh, ram_enl, mdr_load, ram_load, call, ret}) > 1) begin
        miscompares++; $display("FAIL one_strobe: got %b want at most one", {mar_loadh, ram_enh, ram_enl, mdr_load, ram_load, call, ret});
      end
      if (!cpu_ack && cpu_rdata !== 16'h0000) begin
        miscompares++; $display("FAIL rdata_idle_zero: got %h want 0000", cpu_rdata);
      end
      if ((cpu_ack && prev_cpu_ack) || (ldr_ack && prev_ldr_ack) || (cpu_ack && ldr_ack)) begin
        miscompares++; $display("FAIL ack_pulse: got cpu=%b ldr=%b want single-cycle one-port pulse", cpu_ack, ldr_ack);
      end
`ifndef MEMSEQ_LOADER_EN
      if (ldr_ack !== 1'b0) begin
        miscompares++; $display("FAIL ldr_ack_tied: got %b want 0", ldr_ack);
      end
`endif
      if (mar_loadh) cnt[0]++;
      if (ram_enh)   cnt[1]++;
      if (ram_enl)   cnt[2]++;
      if (mdr_load)  cnt[3]++;
      if (ram_load)  cnt[4]++;
      if (call)      cnt[5]++;
      if (ret)       cnt[6]++;
      if (bus_oe)    q_bus.push_back(bus_out);
    end
    prev_cpu_ack = cpu_ack;
    prev_ldr_ack = ldr_ack;
  endtask

  // one CPU operation checked end to end against the op-level reference
  task automatic do_cpu(input logic [2:0] op, input logic [15:0] a, input logic [7:0] d,
                        input bit keep, output logic [15:0] got_rd);
    int lat, exp_lat, n, pre;
    int base [7];
    int exp_cnt [7];
    logic [15:0] exp_bus [$];
    logic [15:0] exp_rd;
    logic [15:0] a1;
    a1 = a + 16'd1;
    exp_cnt = '{0, 0, 0, 0, 0, 0, 0};
    exp_rd = 16'h0000;
    case (op)
      3'd0: begin lat = 3; exp_cnt = '{1, 0, 1, 0, 0, 0, 0}; exp_bus.push_back(a);
              exp_rd = {8'h00, gold_rd(a)}; end
      3'd1: begin lat = 5; exp_cnt = '{2, 1, 1, 0, 0, 0, 0}; exp_bus.push_back(a); exp_bus.push_back(a1);
              exp_rd = {gold_rd(a), gold_rd(a1)}; end
      3'd2: begin lat = 4; exp_cnt = '{1, 0, 0, 1, 1, 0, 0}; exp_bus.push_back(a); exp_bus.push_back({8'h00, d}); end
      3'd3: begin lat = 2; exp_cnt = '{0, 0, 0, 0, 0, 1, 0}; exp_bus.push_back(a); end
      3'd4: begin lat = 2; exp_cnt = '{0, 0, 0, 0, 0, 0, 1}; exp_rd = {gold_rd(16'hFFFE), gold_rd(16'hFFFF)}; end
      default: lat = 1;
    endcase
    pre = in_done ? 1 : 0;
    exp_lat = lat + pre;
    for (int i = 0; i < 7; i++) base[i] = cnt[i];
    q_bus.delete();
    cpu_req = 1'b1; cpu_op = op; cpu_addr = a; cpu_wdata = d;
    n = 0;
    got_rd = 16'h0000;
    while (n < 20) begin
      step();
      n++;
      vectors++;
      if (busy !== (n > pre)) begin
        miscompares++; $display("FAIL busy op%0d cyc%0d: got %b want %b", op, n, busy, n > pre);
      end
      if (cpu_ack) break;
    end
    vectors++;
    if (!cpu_ack) begin
      miscompares++; $display("FAIL ack_timeout op%0d: got no ack want ack at %0d", op, exp_lat);
    end else begin
      got_rd = cpu_rdata;
      vectors++;
      if (n != exp_lat) begin
        miscompares++; $display("FAIL latency op%0d: got %0d want %0d", op, n, exp_lat);
      end
      if (op != 3'd2 && op != 3'd3) begin
        vectors++;
        if (cpu_rdata !== exp_rd) begin
          miscompares++; $display("FAIL rdata op%0d addr %h: got %h want %h", op, a, cpu_rdata, exp_rd);
        end
      end
    end
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (cnt[i] - base[i] != exp_cnt[i]) begin
        miscompares++; $display("FAIL strobe%0d op%0d: got %0d want %0d", i, op, cnt[i] - base[i], exp_cnt[i]);
      end
    end
    vectors++;
    if (q_bus.size() != exp_bus.size()) begin
      miscompares++; $display("FAIL bus_count op%0d: got %0d want %0d", op, q_bus.size(), exp_bus.size());
    end else begin
      foreach (exp_bus[i]) begin
        vectors++;
        if (q_bus[i] !== exp_bus[i]) begin
          miscompares++; $display("FAIL bus_value op%0d #%0d: got %h want %h", op, i, q_bus[i], exp_bus[i]);
        end
      end
    end
    // reference memory update
    if (op == 3'd2) gold[a] = d;
    if (op == 3'd3) begin gold[16'hFFFE] = a[15:8]; gold[16'hFFFF] = a[7:0]; end
    if (keep) begin
      in_done = 1;
    end else begin
      cpu_req = 1'b0;
      step();
      vectors++;
      if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL after_ack op%0d: got ack=%b busy=%b want 0 0", op, cpu_ack, busy);
      end
      in_done = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b0; ldr_req = 1'b0;
    #1;
    vectors++;
    if ({mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret} !== 8'h00) begin
      miscompares++; $display("FAIL reset_strobes: got %b want 0", {mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret});
    end
    vectors++;
    if (bus_out !== 16'h0000 || bus_oe !== 1'b0) begin
      miscompares++; $display("FAIL reset_bus: got %h/%b want 0000/0", bus_out, bus_oe);
    end
    vectors++;
    if (cpu_ack !== 1'b0 || ldr_ack !== 1'b0 || cpu_rdata !== 16'h0000 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got ack=%b/%b rd=%h busy=%b want 0", cpu_ack, ldr_ack, cpu_rdata, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_done = 0;
    prev_cpu_ack = 0; prev_ldr_ack = 0;
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_reset: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_call_ret();
    logic [15:0] r;
    do_cpu(3'd3, 16'h1234, 8'h00, 0, r);
    do_cpu(3'd4, 16'h0000, 8'h00, 0, r);
    vectors++;
    if (r !== 16'h1234) begin
      miscompares++; $display("FAIL ret_value: got %h want 1234", r);
    end
  endtask

  task automatic test_word_wrap();
    logic [15:0] r;
    do_cpu(3'd2, 16'hFFFF, 8'hAB, 0, r);
    do_cpu(3'd2, 16'h0000, 8'hCD, 0, r);
    do_cpu(3'd1, 16'hFFFF, 8'h00, 0, r);
    vectors++;
    if (r !== 16'hABCD) begin
      miscompares++; $display("FAIL word_wrap: got %h want abcd", r);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] r;
    do_cpu(3'd2, 16'h0040, 8'h5A, 0, r);
    do_cpu(3'd0, 16'h0040, 8'h00, 0, r);
    vectors++;
    if (r !== 16'h005A) begin
      miscompares++; $display("FAIL byte_rw: got %h want 005a", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    do_cpu(3'd0, 16'h0041, 8'h00, 1, r);
    do_cpu(3'd2, 16'h0042, 8'h99, 1, r);
    do_cpu(3'd1, 16'h0041, 8'h00, 1, r);
    do_cpu(3'd5, 16'h0000, 8'h00, 0, r);
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    cpu_req = 1'b1; cpu_op = 3'd1; cpu_addr = 16'h2345; cpu_wdata = 8'h00;
    step();
    step();
    vectors++;
    if (ram_enh !== 1'b1) begin
      miscompares++; $display("FAIL reach_rdh: got ram_enh=%b want 1", ram_enh);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret, bus_oe, busy, cpu_ack} !== 11'h000) begin
      miscompares++; $display("FAIL abort_outputs: got %b want 0", {mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret, bus_oe, busy, cpu_ack});
    end
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (cpu_ack !== 1'b0 || busy !== 1'b0 || bus_oe !== 1'b0) begin
        miscompares++; $display("FAIL abort_idle cyc%0d: got ack=%b busy=%b oe=%b want 0", i, cpu_ack, busy, bus_oe);
      end
    end
    in_done = 0;
    do_cpu(3'd6, 16'h1111, 8'h22, 0, r);
  endtask

  task automatic test_random();
    logic [15:0] r, a;
    logic [2:0]  op;
    bit keep;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: a = 16'hFFFF;
        1: a = 16'h0000;
        2: a = 16'hFFFE;
        default: a = 16'h0040 + 16'($urandom_range(0, 7));
      endcase
      keep = (i != 39) && ($urandom_range(0, 1) == 1);
      do_cpu(op, a, 8'($urandom), keep, r);
    end
  endtask

`ifdef MEMSEQ_LOADER_EN
  task automatic test_tie();
    int order [$];
    int when [$];
    int n;
    logic [7:0] old;
    int exp_when [3];
    test_reset();
    old = gold_rd(16'h0100);
    cpu_req = 1'b1; cpu_op = 3'd0; cpu_addr = 16'h0100; cpu_wdata = 8'h00;
    ldr_req = 1'b1; ldr_addr = 16'h0100; ldr_wdata = 8'h77;
    n = 0;
    while (n < 40 && order.size() < 3) begin
      step();
      n++;
      if (cpu_ack) begin
        vectors++;
        if (cpu_rdata !== (order.size() == 0 ? {8'h00, old} : 16'h0077)) begin
          miscompares++; $display("FAIL tie_rdata #%0d: got %h want %h", order.size(), cpu_rdata, order.size() == 0 ? {8'h00, old} : 16'h0077);
        end
        order.push_back(0); when.push_back(n);
        if (order.size() == 3) cpu_req = 1'b0;
      end
      if (ldr_ack) begin
        order.push_back(1); when.push_back(n);
        ldr_req = 1'b0;
        gold[16'h0100] = 8'h77;
      end
    end
    cpu_req = 1'b0;
    step();
    in_done = 0;
    exp_when = '{3, 8, 12};
    vectors++;
    if (order.size() != 3) begin
      miscompares++; $display("FAIL tie_grants: got %0d grants want 3", order.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (order[i] != (i % 2) || when[i] != exp_when[i]) begin
          miscompares++; $display("FAIL tie_order #%0d: got port%0d@%0d want port%0d@%0d", i, order[i], when[i], i % 2, exp_when[i]);
        end
      end
    end
    vectors++;
    if (mem_rd(16'h0100) !== 8'h77) begin
      miscompares++; $display("FAIL ldr_write: got %h want 77", mem_rd(16'h0100));
    end
  endtask
`else
  task automatic test_loader_off();
    logic [15:0] r;
    ldr_req = 1'b1; ldr_addr = 16'h0200; ldr_wdata = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++; $display("FAIL ldr_ignored cyc%0d: got busy=%b want 0", i, busy);
      end
    end
    do_cpu(3'd2, 16'h0200, 8'h31, 0, r);
    do_cpu(3'd1, 16'h01FF, 8'h00, 1, r);
    do_cpu(3'd3, 16'hBEEF, 8'h00, 0, r);
    do_cpu(3'd4, 16'h0000, 8'h00, 0, r);
    vectors++;
    if (mem_rd(16'h0200) !== 8'h31) begin
      miscompares++; $display("FAIL ldr_off_mem: got %h want 31", mem_rd(16'h0200));
    end
    ldr_req = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_op = 3'd0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    ldr_req = 1'b0; ldr_addr = 16'h0000; ldr_wdata = 8'h00;
    for (int i = 0; i < 7; i++) cnt[i] = 0;
    test_reset();
    test_call_ret();
    test_word_wrap();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MEMSEQ_LOADER_EN
    test_tie();
`else
    test_loader_off();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Multi-cycle access sequencer and two-port arbiter for the SAP-2 byte-wide memory (MAR/MDR, fixed return-address slot at 16'hFFFE/16'hFFFF). It accepts byte/word reads, byte writes and call/return stack operations from the CPU control unit, plus byte writes from an optional program loader. It arbitrates between the two, then drives the memory strobes and the shared 16-bit bus one step per clock. It sits between the control unit, the loader and the memory block, and owns the bus whenever `bus_oe` is high.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_req`  in  1  CPU request; held until `cpu_ack`.
- `cpu_op`  in  3  0 READ_B, 1 READ_W, 2 WRITE_B, 3 CALL, 4 RET, 5–7 invalid.
- `cpu_addr`  in  16  access address; for CALL, the return address to push.
- `cpu_wdata`  in  8  write byte.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  16  read result; valid only while `cpu_ack` is high, 0 otherwise.
- `ldr_req`  in  1  loader write request; held until `ldr_ack`.
- `ldr_addr`  in  16  loader write address.
- `ldr_wdata`  in  8  loader write byte.
- `ldr_ack`  out  1  one-cycle completion pulse.
- `mem_out`  in  16  MDR contents from memory.
- `bus_out`  out  16  value driven onto the shared bus; 0 when `bus_oe` is low.
- `bus_oe`  out  1  high in any state that drives `bus_out`.
- `mar_loadh`, `mar_loadl`, `mdr_load`, `ram_load`, `ram_enh`, `ram_enl`, `call`, `ret`  out  1 each  memory strobes.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, MARA, RDH, MARB, RDL, MDR, WR, STK, DONE.
- All outputs are Moore, decoded from the state and the latched request. Only the strobes listed below are ever high.
- **IDLE:** if any request is high, grant one. On the next edge, latch op/addr/wdata and the granted port.
  - A loader grant is always WRITE_B.
- **Arbitration:** round-robin.
  - A lone requester wins.
  - On a tie, the port not granted last wins.
  - `last_grant` resets to LDR, so the CPU wins the first tie.
- **Sequences:**
  - READ_B: MARA (bus=addr, `mar_loadh`, `mar_loadl`) → RDL (`ram_enl`) → DONE, rdata={8'h00, mem_out[7:0]}.
  - READ_W: MARA → RDH (`ram_enh`) → MARB (bus=addr+1 mod 2^16, both MAR loads) → RDL → DONE, rdata=mem_out. Byte order is big-endian: the high byte is at addr. 16'hFFFF wraps to 16'h0000.
  - WRITE_B: MARA → MDR (bus={8'h00,wdata}, `mdr_load`) → WR (`ram_load`) → DONE.
  - CALL: STK (bus=addr, `call`) → DONE.
  - RET: STK (`ret`) → DONE, rdata=mem_out.
  - Invalid op: IDLE → DONE directly; no strobes; rdata=0.
- **DONE:** pulse the granted port's ack, then return to IDLE. A request still high in that IDLE cycle is re-arbitrated. Requesters must drop `req` or present the next request after seeing ack.
- Request inputs are ignored outside IDLE. Changes to op/addr/wdata mid-sequence have no effect.

## Timing
- Reset (asynchronous) forces IDLE, all strobes 0, `bus_oe`=0, `bus_out`=0, both acks 0, `cpu_rdata`=0, `busy`=0, `last_grant`=LDR. Reset mid-sequence aborts it with no ack; the memory sees no further strobes.
- Latency is measured from the IDLE cycle with req high (cycle 0) to the ack cycle: READ_B 3, READ_W 5, WRITE_B 4, CALL 2, RET 2, invalid 1.
- Back-to-back throughput is the latency plus 1 IDLE cycle.
- `busy` is high from cycle 1 through DONE inclusive.

## Configuration
- `MEMSEQ_LOADER_EN` defined: the loader port is active as described above.
- `MEMSEQ_LOADER_EN` undefined:
  - `ldr_req`, `ldr_addr` and `ldr_wdata` are ignored.
  - `ldr_ack` is tied to 0.
  - The arbiter and `last_grant` are removed; the CPU is always granted.

## Test plan
- **Reset and CALL/RET:** after reset, all outputs are 0. CPU CALL addr=16'h1234 → `call` for 1 cycle with bus=16'h1234, ack at cycle 2. Then RET → ack at cycle 2 with `cpu_rdata`=16'h1234.
- **Word read with wrap:** ram[16'hFFFF]=8'hAB, ram[16'h0000]=8'hCD; READ_W addr=16'hFFFF → second MAR load bus=16'h0000; ack at cycle 5 with rdata=16'hABCD.
- **Byte write then read:** WRITE_B addr=16'h0040 wdata=8'h5A → ack at cycle 4. Then READ_B addr=16'h0040 → ack at cycle 3 with rdata=16'h005A.
- **Tie arbitration:** `cpu_req` and `ldr_req` rise together and stay held.
  - Grants go CPU, LDR, CPU.
  - Loader write ldr_addr=16'h0100 ldr_wdata=8'h77 lands in ram[16'h0100].
- **Reset and invalid op:** assert `rst` in RDH of a READ_W → strobes drop immediately, no ack, IDLE after release. Op=6 → ack at cycle 1, rdata=0, no strobe ever high.
- **Loader compiled out:** build without `MEMSEQ_LOADER_EN`; hold `ldr_req` high → `ldr_ack` stays 0 and CPU ops complete with the normal latencies.
